shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter; successor to the team's 8-bit combinational left/right shifter.
- Adds:
  - generic WIDTH;
  - four shift modes (logical right, logical left, arithmetic right, rotate left);
  - one registered pipeline stage per shift-amount bit;
  - valid/ready handshake with backpressure on both sides.
- Sits between an operand source (ALU decode) and a result consumer (writeback mux).

Parameters:
- WIDTH, 8, data width in bits; power of two, >= 4.
- SHW, log2(WIDTH), derived localparam (not overridable); shift-amount width and pipeline depth.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an input this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_op  input  2  mode:
  - 00 logical right;
  - 01 logical left;
  - 10 arithmetic right;
  - 11 rotate left.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data == 0; qualified by out_valid.

Behaviour:
- Reset (asynchronous, active-high, effective immediately, independent of clk):
  - all stage valid bits, out_valid and out_zero clear to 0;
  - all stage data, op and amt registers clear to 0, so out_data = 0;
  - in_ready = 1 once rst deasserts (pipeline empty).
- Structure: SHW stages, S0..S(SHW-1). S(SHW-1) registers drive out_valid, out_data and out_zero directly.
- Stage k holds four registers: valid_k, data_k, op_k, amt_k.
  - Its input is stage k-1's registers, or the in_* ports for k=0.
  - If amt bit k is 1, it applies a shift of 2^k in the carried op; otherwise data passes unchanged.
- Fill rules per mode, applied identically at every stage:
  - logical right: fill with 0 from the MSB side;
  - logical left: fill with 0 from the LSB side;
  - arithmetic right: fill with the current MSB of the stage input (sign of the original operand, because the MSB is preserved stage to stage);
  - rotate left: bits shifted out of the MSB re-enter at the LSB.
- Composition of per-stage shifts equals a single shift by in_amt. No amount is out of range, since in_amt < WIDTH by width.
- Global stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - When advance = 1, every stage loads from its predecessor: valid_0 <= in_valid, data/op/amt follow.
  - When advance = 0, every stage register holds.
- Handshakes:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - in_data, in_amt and in_op are ignored when in_valid = 0. Bubbles propagate as valid = 0 and data registers still load (don't-care).
- Latency: a result appears on out_valid exactly SHW cycles after the accepting edge when unstalled (3 for WIDTH = 8).
- Throughput: one result per cycle while out_ready = 1.
- Ordering: strictly in order; no result dropped or duplicated under any out_ready pattern.
- Stalled output: while out_valid && !out_ready, out_data and out_zero are stable.
- out_zero is computed from the S(SHW-1) data at the final stage's load, so it is registered alongside data.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.
- Reset mid-operation: all in-flight operands are discarded; no partial result is emitted after reset.

Test Plan:
- WIDTH=8, unstalled: in_data=0xB4, in_amt=3, once per op:
  - op 00 -> 0x16;
  - op 01 -> 0xA0;
  - op 10 -> 0xF6;
  - op 11 -> 0xA5.
  - Each appears 3 cycles after acceptance; out_zero=0.
- Boundary amounts, in_data=0x81:
  - amt=0, all ops -> 0x81;
  - amt=7: op00 -> 0x01, op01 -> 0x80, op10 -> 0xFF, op11 -> 0xC0;
  - in_data=0x01, op00, amt=1 -> 0x00 with out_zero=1.
- Back-to-back: 8 consecutive inputs (data=i, op01, amt=1), out_ready=1 -> results 0,2,4,...,14 on 8 consecutive cycles, in order.
- Backpressure:
  - Hold out_ready=0 after 3 accepts -> in_ready=0, out_data held stable, no new input accepted.
  - Release -> remaining results in order, none lost or duplicated.
  - Randomised out_ready over 200 ops checked against a scoreboard.
- Reset mid-stream: assert rst asynchronously between edges with 3 ops in flight -> out_valid=0 and out_data=0 immediately; no stale result after release; the next op yields a correct result with 3-cycle latency.
- WIDTH=32 instance: in_data=0x80000000, op10, amt=31 -> 0xFFFFFFFF after 5 cycles; op11, amt=1 -> 0x00000001.

Source files
------------

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter with valid/ready handshake.
// One registered stage per shift-amount bit; stage k applies a shift of 2^k
// when amount bit k is set. A single global stall freezes every stage while
// the output holds a result the consumer has not taken.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   in_data/in_amt/in_op operand, shift amount, mode (00 lsr, 01 lsl, 10 asr, 11 rol)
//   out_valid/out_ready result handshake
//   out_data/out_zero   shifted result and its zero flag, registered
module shift_pipe #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero
);

   // Shift d by a fixed amount sh in the given mode.
   function automatic logic [WIDTH-1:0] f_stage(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       op,
                                                input int unsigned      sh);
      logic [WIDTH-1:0] r;
      case (op)
         2'b00:   r = d >> sh;
         2'b01:   r = d << sh;
         2'b10:   r = WIDTH'($signed(d) >>> sh);
         default: r = (d << sh) | (d >> (WIDTH - sh));
      endcase
      return r;
   endfunction

   logic [SHW-1:0]            r_valid;
   logic [SHW-1:0][WIDTH-1:0] r_data;
   logic [SHW-1:0][1:0]       r_op;
   logic [SHW-1:0][SHW-1:0]   r_amt;
   logic                      r_zero;

   logic [SHW-1:0]            w_src_valid;
   logic [SHW-1:0][WIDTH-1:0] w_src_data;
   logic [SHW-1:0][1:0]       w_src_op;
   logic [SHW-1:0][SHW-1:0]   w_src_amt;
   logic [SHW-1:0][WIDTH-1:0] w_nxt_data;
   logic                      w_advance;
   logic                      w_unused;

   // Whole pipeline moves together unless the output is blocked.
   assign w_advance = !r_valid[SHW-1] || out_ready;
   assign in_ready  = w_advance;

   // Stage inputs and per-stage conditional shift.
   for (genvar k = 0; k < SHW; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign w_src_valid[k] = in_valid;
         assign w_src_data[k]  = in_data;
         assign w_src_op[k]    = in_op;
         assign w_src_amt[k]   = in_amt;
      end else begin : g_rest
         assign w_src_valid[k] = r_valid[k-1];
         assign w_src_data[k]  = r_data[k-1];
         assign w_src_op[k]    = r_op[k-1];
         assign w_src_amt[k]   = r_amt[k-1];
      end
      assign w_nxt_data[k] = w_src_amt[k][k]
                           ? f_stage(w_src_data[k], w_src_op[k], 32'd1 << k)
                           : w_src_data[k];
   end

   // The last stage's op and the already-consumed amount bits feed nothing.
   assign w_unused = ^{r_op[SHW-1], r_amt};

   // Pipeline registers; all stages load together on advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_data  <= '0;
         r_op    <= '0;
         r_amt   <= '0;
         r_zero  <= 1'b0;
      end else if (w_advance) begin
         r_valid <= w_src_valid;
         r_data  <= w_nxt_data;
         r_op    <= w_src_op;
         r_amt   <= w_src_amt;
         r_zero  <= (w_nxt_data[SHW-1] == '0);
      end
   end

   assign out_valid = r_valid[SHW-1];
   assign out_data  = r_data[SHW-1];
   assign out_zero  = r_zero;

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and scoreboard bench for shift_pipe (WIDTH=8 and WIDTH=32).
module tb_shift_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic       in_valid, in_ready, out_valid, out_ready, out_zero;
   logic [7:0] in_data, out_data;
   logic [2:0] in_amt;
   logic [1:0] in_op;

   logic        v32_in_valid, v32_in_ready, v32_out_valid, v32_out_ready, v32_out_zero;
   logic [31:0] v32_in_data, v32_out_data;
   logic [4:0]  v32_in_amt;
   logic [1:0]  v32_in_op;

   shift_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_amt(in_amt), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_zero(out_zero)
   );

   shift_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst),
      .in_valid(v32_in_valid), .in_ready(v32_in_ready), .in_data(v32_in_data),
      .in_amt(v32_in_amt), .in_op(v32_in_op),
      .out_valid(v32_out_valid), .out_ready(v32_out_ready),
      .out_data(v32_out_data), .out_zero(v32_out_zero)
   );

   typedef struct {
      logic [7:0] d;
      logic [2:0] a;
      logic [1:0] op;
      logic [7:0] exp;
      logic       ez;
   } vec_t;

   int         total = 0;
   int         bad   = 0;
   int         pops  = 0;
   int         acc_cnt = 0;
   logic       last_acc;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic       prev_zero;
   logic [7:0] sbq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Bitwise reference: each result bit picks its source bit directly.
   function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a,
                                        input logic [1:0] op);
      logic [7:0] r;
      int sa;
      sa = int'(a);
      for (int i = 0; i < 8; i++) begin
         case (op)
            2'b00:   r[i] = (i + sa < 8) ? d[i + sa] : 1'b0;
            2'b01:   r[i] = (i >= sa) ? d[i - sa] : 1'b0;
            2'b10:   r[i] = (i + sa < 8) ? d[i + sa] : d[7];
            default: r[i] = d[(i - sa + 8) % 8];
         endcase
      end
      return r;
   endfunction

   // One cycle: drive at negedge, sample state left by the previous posedge.
   task automatic cyc(input logic iv, input logic [7:0] d, input logic [2:0] a,
                      input logic [1:0] op, input logic ordy,
                      output logic ov, output logic [7:0] od, output logic oz,
                      output logic acc);
      @(negedge clk);
      in_valid = iv; in_data = d; in_amt = a; in_op = op; out_ready = ordy;
      #1;
      ov = out_valid; od = out_data; oz = out_zero;
      acc = in_valid && in_ready;
   endtask

   task automatic sb_cyc(input logic iv, input logic [7:0] d, input logic [2:0] a,
                         input logic [1:0] op, input logic ordy);
      logic ov, oz, acc;
      logic [7:0] od, e;
      cyc(iv, d, a, op, ordy, ov, od, oz, acc);
      if (prev_stall) begin
         chk("stall_valid", 32'(ov), 32'd1);
         chk("stall_data", 32'(od), 32'(prev_data));
         chk("stall_zero", 32'(oz), 32'(prev_zero));
      end
      prev_stall = ov && !ordy;
      prev_data  = od;
      prev_zero  = oz;
      if (ov && ordy) begin
         if (sbq.size() == 0) chk("sb_spurious_valid", 32'(ov), 32'd0);
         else begin
            e = sbq.pop_front();
            chk("sb_data", 32'(od), 32'(e));
            chk("sb_zero", 32'(oz), 32'(e == 8'h00));
            pops++;
         end
      end
      last_acc = acc;
      if (acc) begin
         sbq.push_back(model(d, a, op));
         acc_cnt++;
      end
   endtask

   // Single isolated op: checks acceptance, latency, data and zero flag.
   task automatic run_vec(input vec_t v);
      logic ov, oz, acc;
      logic [7:0] od;
      int lat;
      cyc(1'b1, v.d, v.a, v.op, 1'b1, ov, od, oz, acc);
      chk("vec_acc", 32'(acc), 32'd1);
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         cyc(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, ov, od, oz, acc);
         if (ov) begin
            lat = c;
            break;
         end
      end
      chk("vec_latency", 32'(lat), 32'd3);
      chk("vec_data", 32'(od), 32'(v.exp));
      chk("vec_zero", 32'(oz), 32'(v.ez));
   endtask

   task automatic run32(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                        input logic [31:0] exp);
      int lat;
      @(negedge clk);
      v32_in_valid = 1'b1; v32_in_data = d; v32_in_amt = a; v32_in_op = op;
      #1;
      chk("w32_acc", 32'(v32_in_ready), 32'd1);
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         v32_in_valid = 1'b0;
         #1;
         if (v32_out_valid) begin
            lat = c;
            break;
         end
      end
      chk("w32_latency", 32'(lat), 32'd5);
      chk("w32_data", v32_out_data, exp);
      chk("w32_zero", 32'(v32_out_zero), 32'(exp == 32'h0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[14];
      logic ov, oz, acc, iv, r;
      logic [7:0] od;
      int p0, a0, cycles;

      vecs[0]  = '{8'hB4, 3'd3, 2'b00, 8'h16, 1'b0};
      vecs[1]  = '{8'hB4, 3'd3, 2'b01, 8'hA0, 1'b0};
      vecs[2]  = '{8'hB4, 3'd3, 2'b10, 8'hF6, 1'b0};
      vecs[3]  = '{8'hB4, 3'd3, 2'b11, 8'hA5, 1'b0};
      vecs[4]  = '{8'h81, 3'd0, 2'b00, 8'h81, 1'b0};
      vecs[5]  = '{8'h81, 3'd0, 2'b01, 8'h81, 1'b0};
      vecs[6]  = '{8'h81, 3'd0, 2'b10, 8'h81, 1'b0};
      vecs[7]  = '{8'h81, 3'd0, 2'b11, 8'h81, 1'b0};
      vecs[8]  = '{8'h81, 3'd7, 2'b00, 8'h01, 1'b0};
      vecs[9]  = '{8'h81, 3'd7, 2'b01, 8'h80, 1'b0};
      vecs[10] = '{8'h81, 3'd7, 2'b10, 8'hFF, 1'b0};
      vecs[11] = '{8'h81, 3'd7, 2'b11, 8'hC0, 1'b0};
      vecs[12] = '{8'h01, 3'd1, 2'b00, 8'h00, 1'b1};
      vecs[13] = '{8'h7F, 3'd2, 2'b10, 8'h1F, 1'b0};

      in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
      v32_in_valid = 1'b0; v32_in_data = '0; v32_in_amt = '0; v32_in_op = '0;
      v32_out_ready = 1'b1;

      // Reset state
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_zero", 32'(out_zero), 32'd0);
      chk("rst_w32_out_valid", 32'(v32_out_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed single ops
      foreach (vecs[i]) run_vec(vecs[i]);

      // Back-to-back: one result per cycle
      p0 = pops;
      for (int i = 0; i < 8; i++) begin
         sb_cyc(1'b1, 8'(i), 3'd1, 2'b01, 1'b1);
         chk("b2b_acc", 32'(last_acc), 32'd1);
      end
      for (int i = 0; i < 3; i++) sb_cyc(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      chk("b2b_pops", 32'(pops - p0), 32'd8);
      chk("b2b_empty", 32'(sbq.size()), 32'd0);

      // Backpressure: fill, stall, release
      p0 = pops;
      for (int i = 0; i < 3; i++) begin
         sb_cyc(1'b1, 8'(10 + i), 3'd2, 2'b00, 1'b0);
         chk("bp_fill_acc", 32'(last_acc), 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
         sb_cyc(1'b1, 8'hEE, 3'd1, 2'b00, 1'b0);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_no_accept", 32'(last_acc), 32'd0);
      end
      for (int i = 0; i < 6; i++) sb_cyc(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      chk("bp_pops", 32'(pops - p0), 32'd3);
      chk("bp_empty", 32'(sbq.size()), 32'd0);

      // Random out_ready over 200 ops
      a0 = acc_cnt;
      cycles = 0;
      while ((acc_cnt - a0) < 200 && cycles < 3000) begin
         iv = ($urandom_range(0, 3) != 0);
         r  = 1'($urandom_range(0, 1));
         sb_cyc(iv, 8'($urandom), 3'($urandom), 2'($urandom), r);
         cycles++;
      end
      for (int c = 0; c < 50 && sbq.size() > 0; c++) sb_cyc(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      chk("rand_accepts", 32'(acc_cnt - a0), 32'd200);
      chk("rand_drained", 32'(sbq.size()), 32'd0);

      // Reset mid-stream with ops in flight
      for (int i = 0; i < 3; i++) sb_cyc(1'b1, 8'hF0, 3'd4, 2'b11, 1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      sbq.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, ov, od, oz, acc);
         chk("midrst_no_stale", 32'(ov), 32'd0);
      end
      run_vec(vecs[1]);

      // WIDTH=32 instance
      run32(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
      run32(32'h8000_0000, 5'd1,  2'b11, 32'h0000_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
